// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, oversampling constants and voter
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int MID        = OVERSAMPLE / 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_DONE  = 3'd4
   } uart_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input and received-byte outputs of the UART receiver
interface uart_rx_if;

   logic       rx;
   logic [7:0] data_out;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;
   logic [2:0] state;
   logic       clk_enable;

   modport master (
      input  rx,
      output data_out, rx_valid, frame_err, busy, state, clk_enable
   );

   modport slave (
      output rx,
      input  data_out, rx_valid, frame_err, busy, state, clk_enable
   );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, resets to idle-high
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], async_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver with 3-sample majority voting
module uart_rx
   import uart_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   uart_rx_if.master rx_if
);

   localparam logic [3:0] SAMP_A = 4'(MID - 1);
   localparam logic [3:0] SAMP_B = 4'(MID);
   localparam logic [3:0] SAMP_C = 4'(MID + 1);
   localparam logic [3:0] LAST   = 4'(OVERSAMPLE - 1);

   logic        rx_sync;
   uart_state_e state_q, state_d;
   logic [3:0]  baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [1:0]  samp_q, samp_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic        armed_q, armed_d;
   logic        clk_en_q, clk_en_d;
   logic        bit_val;

   uart_rx_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (rx_if.rx),
      .sync_out (rx_sync)
   );

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 4'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      samp_d  = samp_q;
      data_d  = data_q;
      err_d   = err_q;
      valid_d = 1'b0;
      armed_d = armed_q;
      // The third vote is the live sample, so the decision lands at SAMP_C
      bit_val = maj3(samp_q[1], samp_q[0], rx_sync);

      if (baud_q == SAMP_A) samp_d[1] = rx_sync;
      if (baud_q == SAMP_B) samp_d[0] = rx_sync;

      case (state_q)
         ST_IDLE: begin
            baud_d = 4'd0;
            if (rx_sync) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (baud_q == SAMP_C && bit_val) begin
               state_d = ST_IDLE;
               baud_d  = 4'd0;
            end else if (baud_q == LAST) begin
               state_d = ST_DATA;
               baud_d  = 4'd0;
               bit_d   = 3'd0;
            end
         end
         ST_DATA: begin
            if (baud_q == SAMP_C) begin
               shift_d = {bit_val, shift_q[7:1]};
            end else if (baud_q == LAST) begin
               baud_d = 4'd0;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         ST_STOP: begin
            // Leave at mid-stop so a following start edge is never missed
            if (baud_q == SAMP_C) begin
               data_d  = shift_q;
               err_d   = ~bit_val;
               valid_d = 1'b1;
               state_d = ST_DONE;
               baud_d  = 4'd0;
               if (!bit_val) armed_d = 1'b0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            baud_d  = 4'd0;
         end
         default: begin
            state_d = ST_IDLE;
            baud_d  = 4'd0;
         end
      endcase

      clk_en_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         baud_q   <= 4'd0;
         bit_q    <= 3'd0;
         shift_q  <= 8'd0;
         samp_q   <= 2'b00;
         data_q   <= 8'd0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         armed_q  <= 1'b1;
         clk_en_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         samp_q   <= samp_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         armed_q  <= armed_d;
         clk_en_q <= clk_en_d;
      end
   end

   assign rx_if.data_out   = data_q;
   assign rx_if.rx_valid   = valid_q;
   assign rx_if.frame_err  = err_q;
   assign rx_if.busy       = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
   assign rx_if.state      = state_q;
   assign rx_if.clk_enable = clk_en_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with directed frames
module tb_uart_rx;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   uart_rx_if u_if ();

   uart_rx dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx_if (u_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         due;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   // rx_valid appears 2 synchronizer edges plus 155 edges after the line falls
   always @(negedge clk) begin
      exp_t e;
      if (u_if.rx_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_valid: got data 0x%0h, expected no pulse", u_if.data_out);
         end else begin
            e = exp_q.pop_front();
            check("data_out", 32'(u_if.data_out), 32'(e.data));
            check("frame_err", 32'(u_if.frame_err), 32'(e.err));
            check("valid_latency", cyc, e.due);
            check("busy_in_done", 32'(u_if.busy), 32'd0);
            check("clk_en_in_done", 32'(u_if.clk_enable), 32'd1);
         end
      end
   end

   task automatic hold(input logic v, input int n);
      u_if.rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bit_out(input logic v, input logic glitch);
      if (glitch) begin
         hold(v, 9);
         hold(~v, 1);
         hold(v, 6);
      end else begin
         hold(v, 16);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input logic glitch);
      exp_t e;
      e.data = b;
      e.err  = ~stop;
      e.due  = cyc + 157;
      exp_q.push_back(e);
      bit_out(1'b0, glitch);
      for (int i = 0; i < 8; i++) bit_out(b[i], glitch);
      bit_out(stop, glitch);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, 32'(u_if.state), 32'd0);
      check({tag, "_data_out"}, 32'(u_if.data_out), 32'd0);
      check({tag, "_rx_valid"}, 32'(u_if.rx_valid), 32'd0);
      check({tag, "_frame_err"}, 32'(u_if.frame_err), 32'd0);
      check({tag, "_busy"}, 32'(u_if.busy), 32'd0);
      check({tag, "_clk_enable"}, 32'(u_if.clk_enable), 32'd1);
   endtask

   initial begin
      int c;
      u_if.rx = 1'b1;
      rst_n   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst_n = 1'b1;
      hold(1'b1, 10);

      send_frame(8'hA5, 1'b1, 1'b0);
      hold(1'b1, 20);

      // 5-cycle low glitch: START entered, rejected at baud_cnt 9
      c = cyc;
      hold(1'b0, 5);
      u_if.rx = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      check("glitch_in_start", 32'(u_if.state), 32'd1);
      check("glitch_clk_en_on", 32'(u_if.clk_enable), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("glitch_cycle", cyc, c + 14);
      check("glitch_back_idle", 32'(u_if.state), 32'd0);
      check("glitch_clk_en_off", 32'(u_if.clk_enable), 32'd0);
      hold(1'b1, 20);

      send_frame(8'h3C, 1'b0, 1'b0);
      hold(1'b0, 200);
      check("break_idle", 32'(u_if.state), 32'd0);
      check("break_busy", 32'(u_if.busy), 32'd0);
      hold(1'b1, 20);
      send_frame(8'hC3, 1'b1, 1'b0);
      hold(1'b1, 20);

      send_frame(8'h55, 1'b1, 1'b1);
      hold(1'b1, 20);

      // 0xFF aborted by reset in the middle of data bit 4
      hold(1'b0, 16);
      for (int i = 0; i < 4; i++) hold(1'b1, 16);
      hold(1'b1, 8);
      rst_n = 1'b0;
      hold(1'b1, 2);
      check_reset_outputs("mid_frame_rst");
      rst_n = 1'b1;
      hold(1'b1, 120);
      check("post_rst_idle", 32'(u_if.state), 32'd0);
      send_frame(8'h81, 1'b1, 1'b0);
      hold(1'b1, 20);

      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      hold(1'b1, 30);

      check("frames_outstanding", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
